// File: rtl/stage_banner_sequencer.sv
// Banner draw/hold/erase sequencer: copies a ROM banner onto the VGA pixel stream, holds it,
// then restores the region from the background RAM. Optional macro: TRANSPARENT_KEY_EN.
module stage_banner_sequencer #(
  parameter int unsigned NUM_BANNERS = 8,
  parameter int unsigned BANNER_W    = 80,
  parameter int unsigned BANNER_H    = 40,
  parameter int unsigned ORIGIN_X    = 40,
  parameter int unsigned ORIGIN_Y    = 40,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter int unsigned COLOUR_W    = 9,
  parameter int unsigned IDW         = (NUM_BANNERS > 1) ? $clog2(NUM_BANNERS) : 1,
  parameter int unsigned ROM_AW      = $clog2(NUM_BANNERS * BANNER_W * BANNER_H)
`ifdef TRANSPARENT_KEY_EN
  ,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(9'h1FF)
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic [IDW-1:0]      banner_id,
  input  logic                sticky,
  input  logic                skip,
  output logic                busy,
  output logic                done,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [14:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_we
);

  localparam int unsigned NumPix   = BANNER_W * BANNER_H;
  localparam logic [7:0]  CxLast   = 8'(BANNER_W - 1);
  localparam logic [6:0]  CyLast   = 7'(BANNER_H - 1);
  // Counter is loaded with one less so HOLD lasts exactly HOLD_CYCLES cycles (minimum 1).
  localparam logic [31:0] HoldLoad = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDraw, StHold, StErase, StDone} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                sticky_q, sticky_d;
  logic [7:0]          cx_q, cx_d;
  logic [6:0]          cy_q, cy_d;
  logic [31:0]         hold_q, hold_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [14:0]         bg_addr_q, bg_addr_d;
  logic                we_q, we_d;
  logic                src_bg_q, src_bg_d;
  logic [7:0]          px_q, px_d;
  logic [6:0]          py_q, py_d;
  logic                last_pix;
  logic                key_hit;

  assign last_pix = (cx_q == CxLast) && (cy_q == CyLast);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    sticky_d   = sticky_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    hold_d     = hold_q;
    rom_addr_d = rom_addr_q;
    bg_addr_d  = bg_addr_q;
    we_d       = 1'b0;
    src_bg_d   = src_bg_q;
    px_d       = px_q;
    py_d       = py_q;

    unique case (state_q)
      StIdle: begin
        if (req && (32'(banner_id) < NUM_BANNERS)) begin
          state_d  = StDraw;
          id_d     = banner_id;
          sticky_d = sticky;
          cx_d     = '0;
          cy_d     = '0;
        end
      end
      StDraw, StErase: begin
        // Address issued this cycle; its pixel is written next cycle with the returned data.
        we_d     = 1'b1;
        src_bg_d = (state_q == StErase);
        px_d     = 8'(ORIGIN_X + 32'(cx_q));
        py_d     = 7'(ORIGIN_Y + 32'(cy_q));
        if (last_pix) begin
          cx_d = '0;
          cy_d = '0;
          if ((state_q == StErase) || sticky_q) begin
            state_d = StDone;
          end else begin
            state_d = StHold;
            hold_d  = HoldLoad;
          end
        end else if (cx_q == CxLast) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      StHold: begin
        if ((hold_q == 32'd0) || skip) begin
          state_d = StErase;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StDraw) begin
      rom_addr_d = ROM_AW'(32'(id_d) * NumPix + 32'(cy_d) * BANNER_W + 32'(cx_d));
    end
    if (state_d == StErase) begin
      bg_addr_d = 15'((ORIGIN_Y + 32'(cy_d)) * SCREEN_W + ORIGIN_X + 32'(cx_d));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      id_q       <= '0;
      sticky_q   <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      hold_q     <= '0;
      rom_addr_q <= '0;
      bg_addr_q  <= '0;
      we_q       <= 1'b0;
      src_bg_q   <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      sticky_q   <= sticky_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      hold_q     <= hold_d;
      rom_addr_q <= rom_addr_d;
      bg_addr_q  <= bg_addr_d;
      we_q       <= we_d;
      src_bg_q   <= src_bg_d;
      px_q       <= px_d;
      py_q       <= py_d;
    end
  end

`ifdef TRANSPARENT_KEY_EN
  assign key_hit = we_q && !src_bg_q && (rom_data == KEY_COLOUR);
`else
  assign key_hit = 1'b0;
`endif

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign rom_addr   = rom_addr_q;
  assign bg_addr    = bg_addr_q;
  assign vga_x      = px_q;
  assign vga_y      = py_q;
  assign vga_we     = we_q && !key_hit;
  assign vga_colour = we_q ? (src_bg_q ? bg_data : rom_data) : '0;

endmodule

// File: tb/tb_stage_banner_sequencer.sv
// Randomised bench for stage_banner_sequencer: per-cycle pixel stream, busy and done are checked
// against an index-based model of the draw/hold/erase timeline.
module tb_stage_banner_sequencer;

  localparam int NB   = 5;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int OX   = 10;
  localparam int OY   = 20;
  localparam int SW   = 160;
  localparam int HOLD = 5;
  localparam int N    = W * H;
`ifdef TRANSPARENT_KEY_EN
  localparam logic [8:0] KEY = 9'h1FF;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       we;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] colour;
  } obs_t;

  logic        clk, resetn, req, sticky, skip, busy, done, vga_we;
  logic [2:0]  banner_id;
  logic [5:0]  rom_addr;
  logic [8:0]  rom_data, bg_data, vga_colour;
  logic [14:0] bg_addr;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;

  logic [8:0]  rom_mem [0:63];
  logic [8:0]  bg_seed;
  obs_t        obs [0:63];
  logic [5:0]  ra [0:63];
  logic [14:0] ba [0:63];
  int          compared, mismatched;

  stage_banner_sequencer #(
    .NUM_BANNERS(NB), .BANNER_W(W), .BANNER_H(H), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .SCREEN_W(SW), .HOLD_CYCLES(HOLD), .COLOUR_W(9)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .banner_id(banner_id), .sticky(sticky),
    .skip(skip), .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .bg_addr(bg_addr), .bg_data(bg_data), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_we(vga_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] bg_hash(input int addr);
    return 9'((addr * 37) ^ int'(bg_seed));
  endfunction

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr];
    bg_data  <= bg_hash(int'(bg_addr));
  end

  // Expected outputs in cycle k after the accepting edge (k=0 is the first busy cycle).
  function automatic obs_t expect_at(input int k, input int id, input bit stk, input int hlen);
    obs_t e;
    int done_k, es, i;
    e      = '0;
    done_k = stk ? N : 2 * N + hlen;
    es     = N + hlen + 1;
    e.busy = (k <= done_k);
    e.done = (k == done_k);
    if (k >= 1 && k <= N) begin
      i        = k - 1;
      e.we     = 1'b1;
      e.x      = 8'(OX + i % W);
      e.y      = 7'(OY + i / W);
      e.colour = rom_mem[id * N + i];
`ifdef TRANSPARENT_KEY_EN
      if (e.colour == KEY) e.we = 1'b0;
`endif
    end else if (!stk && k >= es && k < es + N) begin
      i        = k - es;
      e.we     = 1'b1;
      e.x      = 8'(OX + i % W);
      e.y      = 7'(OY + i / W);
      e.colour = bg_hash((OY + i / W) * SW + OX + i % W);
    end
    if (!e.we) begin
      e.x = '0; e.y = '0; e.colour = '0;
    end
    return e;
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o.busy = busy; o.done = done; o.we = vga_we;
    o.x = vga_we ? vga_x : '0;
    o.y = vga_we ? vga_y : '0;
    o.colour = vga_we ? vga_colour : '0;
    return o;
  endfunction

  // Issues a request, then records win cycles; optional extra req / skip pulse at given cycles.
  task automatic run_op(input int id, input bit stk, input int skip_k, input int req_k,
                        input int req_id, input int win);
    @(negedge clk);
    req = 1'b1; banner_id = 3'(id); sticky = stk; skip = 1'b0;
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      obs[k] = sample_obs();
      ra[k]  = rom_addr;
      ba[k]  = bg_addr;
      req    = (k == req_k);
      if (k == req_k) banner_id = 3'(req_id);
      skip   = (k == skip_k);
    end
    req = 1'b0; skip = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    compared++;
    if ({busy, done, vga_we, vga_x, vga_y, vga_colour, rom_addr, bg_addr} !== 48'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h required=0",
               {busy, done, vga_we, vga_x, vga_y, vga_colour, rom_addr, bg_addr});
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy, done, vga_we} !== 3'b000) begin
      mismatched++;
      $display("FAIL idle_after_reset got=%b required=000", {busy, done, vga_we});
    end
  endtask

  task automatic test_basic();
    int win;
    obs_t e;
    win = 2 * N + HOLD + 3;
    run_op(2, 1'b0, -1, -1, 0, win);
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, 2, 1'b0, HOLD);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL basic k=%0d got=%h required=%h", k, obs[k], e);
      end
    end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (ra[i] !== 6'(2 * N + i)) begin
        mismatched++;
        $display("FAIL basic_rom_addr i=%0d got=%0d required=%0d", i, ra[i], 2 * N + i);
      end
      compared++;
      if (ba[N + HOLD + i] !== 15'((OY + i / W) * SW + OX + i % W)) begin
        mismatched++;
        $display("FAIL basic_bg_addr i=%0d got=%0d required=%0d", i, ba[N + HOLD + i],
                 (OY + i / W) * SW + OX + i % W);
      end
    end
  endtask

  task automatic test_sticky();
    int win;
    obs_t e;
    logic [14:0] bg_before;
    bg_before = bg_addr;
    win = N + 4;
    // Extra req lands in the DONE cycle and must be dropped.
    run_op(3, 1'b1, -1, N, 1, win);
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, 3, 1'b1, HOLD);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL sticky k=%0d got=%h required=%h", k, obs[k], e);
      end
    end
    compared++;
    if (bg_addr !== bg_before) begin
      mismatched++;
      $display("FAIL sticky_bg_idle got=%0d required=%0d", bg_addr, bg_before);
    end
  endtask

  task automatic test_skip();
    int win, id;
    obs_t e;
    id  = int'($urandom_range(0, NB - 1));
    win = 2 * N + 2 + 3;
    run_op(id, 1'b0, N + 1, -1, 0, win);
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, id, 1'b0, 2);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL skip k=%0d got=%h required=%h", k, obs[k], e);
      end
    end
  endtask

  task automatic test_ignored();
    int win, id;
    obs_t e;
    id  = int'($urandom_range(0, NB - 1));
    win = 2 * N + HOLD + 3;
    // req mid-DRAW with a different id and a skip during DRAW: neither may change anything.
    run_op(id, 1'b0, 2, 3, (id + 1) % NB, win);
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, id, 1'b0, HOLD);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL ignored_req k=%0d got=%h required=%h", k, obs[k], e);
      end
    end
    @(negedge clk);
    req = 1'b1; banner_id = 3'($urandom_range(NB, 7)); sticky = 1'b0;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      compared++;
      if ({busy, vga_we} !== 2'b00) begin
        mismatched++;
        $display("FAIL invalid_id k=%0d got=%b required=00", k, {busy, vga_we});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_erase();
    int win, id;
    obs_t e;
    id = int'($urandom_range(0, NB - 1));
    @(negedge clk);
    req = 1'b1; banner_id = 3'(id); sticky = 1'b0;
    for (int k = 0; k < N + HOLD + 3; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    compared++;
    if ({busy, done, vga_we, vga_x, vga_y, vga_colour, rom_addr, bg_addr} !== 48'd0) begin
      mismatched++;
      $display("FAIL async_reset got=%h required=0",
               {busy, done, vga_we, vga_x, vga_y, vga_colour, rom_addr, bg_addr});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, done} !== 2'b00) begin
        mismatched++;
        $display("FAIL reset_hold k=%0d got=%b required=00", k, {busy, done});
      end
    end
    resetn = 1'b1;
    id  = int'($urandom_range(0, NB - 1));
    win = 2 * N + HOLD + 3;
    run_op(id, 1'b0, -1, -1, 0, win);
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, id, 1'b0, HOLD);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL after_reset k=%0d got=%h required=%h", k, obs[k], e);
      end
    end
  endtask

`ifdef TRANSPARENT_KEY_EN
  task automatic test_key();
    int win, id, dw, ew;
    obs_t e;
    id = int'($urandom_range(0, NB - 1));
    rom_mem[id * N + 3] = KEY;
    win = 2 * N + HOLD + 3;
    run_op(id, 1'b0, -1, -1, 0, win);
    dw = 0; ew = 0;
    for (int k = 0; k < win; k++) begin
      e = expect_at(k, id, 1'b0, HOLD);
      compared++;
      if (obs[k] !== e) begin
        mismatched++;
        $display("FAIL key k=%0d got=%h required=%h", k, obs[k], e);
      end
      if (obs[k].we && k <= N) dw++;
      if (obs[k].we && k > N) ew++;
    end
    compared++;
    if (dw != 7 || ew != 8) begin
      mismatched++;
      $display("FAIL key_counts got=%0d/%0d required=7/8", dw, ew);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    compared = 0; mismatched = 0;
    resetn = 1'b0; req = 1'b0; banner_id = '0; sticky = 1'b0; skip = 1'b0;
    bg_seed = 9'($urandom);
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = 9'($urandom);
`ifdef TRANSPARENT_KEY_EN
      if (rom_mem[i] == KEY) rom_mem[i] = 9'h0AA;
`endif
    end
    test_reset();
    test_basic();
    test_sticky();
    test_skip();
    test_ignored();
    test_reset_mid_erase();
`ifdef TRANSPARENT_KEY_EN
    test_key();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
